// File: rtl/spmv_sram_responder_if.sv
// Signal bundle between the responder and its controller, host loader and readback consumer.
// Latency: none, wires only.
// Backpressure: the host load port uses valid/ready; the controller and readback ports have none.
interface spmv_sram_responder_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 5,
  parameter int HOST_W = 32
);
  // controller SRAM port
  logic [ADDR_W-1:0] i_address_A;
  logic [ADDR_W-1:0] i_address_B;
  logic              i_wr_en_A;
  logic              i_wr_en_B;
  logic [DATA_W-1:0] i_write_data_A;
  logic [DATA_W-1:0] i_write_data_B;
  logic [DATA_W-1:0] o_read_data_A;
  logic [DATA_W-1:0] o_read_data_B;
  // host load port
  logic              i_host_valid;
  logic              o_host_ready;
  logic              i_host_bank;
  logic [ADDR_W-1:0] i_host_addr;
  logic [HOST_W-1:0] i_host_data;
  logic              o_host_err;
  // run control and readback
  logic              i_start;
  logic              i_rd_req;
  logic              i_rd_bank;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_valid;
  logic [HOST_W-1:0] o_rd_data;
  logic              o_busy;
  logic              o_done;

  modport slave (
    input  i_address_A, i_address_B, i_wr_en_A, i_wr_en_B, i_write_data_A, i_write_data_B,
    output o_read_data_A, o_read_data_B,
    input  i_host_valid, i_host_bank, i_host_addr, i_host_data,
    output o_host_ready, o_host_err,
    input  i_start, i_rd_req, i_rd_bank, i_rd_addr,
    output o_rd_valid, o_rd_data, o_busy, o_done
  );

  modport master (
    output i_address_A, i_address_B, i_wr_en_A, i_wr_en_B, i_write_data_A, i_write_data_B,
    input  o_read_data_A, o_read_data_B,
    output i_host_valid, i_host_bank, i_host_addr, i_host_data,
    input  o_host_ready, o_host_err,
    output i_start, i_rd_req, i_rd_bank, i_rd_addr,
    input  o_rd_valid, o_rd_data, o_busy, o_done
  );
endinterface

// File: rtl/spmv_sram_responder.sv
// Two-bank SRAM responder for the SpMV controller, with host line load, run start and line readback.
// Latency: controller reads 1 cycle (read-first); readback beats begin 2 cycles after the request edge.
// Backpressure: host ready is high only in IDLE/LOAD; controller and readback ports never stall.
module spmv_sram_responder #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 5,
  parameter int HOST_W = 32
) (
  input logic                  i_clk,
  input logic                  i_rst,
  spmv_sram_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BEATS = DATA_W / HOST_W;
  localparam int CNT_W = $clog2(BEATS);
  // readback phases: 0 = capture, 1 = pipeline slot, 2..BEATS+1 = beats
  localparam int RD_W  = $clog2(BEATS + 2);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, READ} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] asm_line;
  logic              hbank;
  logic [ADDR_W-1:0] haddr;
  logic              rbank;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rd_line;
  logic [RD_W-1:0]   rd_cnt;
  logic [CNT_W-1:0]  rd_beat;

  logic              beat_acc;
  logic              first_beat;
  logic              last_beat;
  logic              collide;
  logic              commit;
  logic              start_acc;
  logic              rd_acc;
  logic              run_done;
  logic [DATA_W-1:0] commit_line;

  assign beat_acc   = bus.i_host_valid && bus.o_host_ready;
  assign first_beat = beat_acc && (state == IDLE);
  assign last_beat  = beat_acc && (state == LOAD) && (cnt == CNT_W'(BEATS - 1));
  // the controller owns the SRAM: a same-line controller write on the commit edge discards the host line
  assign collide    = hbank ? (bus.i_wr_en_B && (bus.i_address_B == haddr))
                            : (bus.i_wr_en_A && (bus.i_address_A == haddr));
  assign commit     = last_beat && !collide;
  assign start_acc  = (state == IDLE) && !beat_acc && bus.i_start;
  assign rd_acc     = (state == IDLE) && !beat_acc && !bus.i_start && bus.i_rd_req;
  assign run_done   = (state == RUN) && bus.i_wr_en_A && (bus.i_address_A == '0) &&
                      bus.i_write_data_A[1];
  // the final beat goes straight into the committed line without passing through the assembly register
  assign commit_line = {bus.i_host_data, asm_line[DATA_W-HOST_W-1:0]};

  // Bank A storage: host commit, then run flag, then controller write so the controller wins any overlap.
  always_ff @(posedge i_clk) begin
    if (commit && !hbank) mem_a[haddr] <= commit_line;
    if (start_acc) mem_a[0] <= DATA_W'(1);
    if (bus.i_wr_en_A) mem_a[bus.i_address_A] <= bus.i_write_data_A;
  end

  // Bank B storage: host commit, then controller write.
  always_ff @(posedge i_clk) begin
    if (commit && hbank) mem_b[haddr] <= commit_line;
    if (bus.i_wr_en_B) mem_b[bus.i_address_B] <= bus.i_write_data_B;
  end

  // Registered read-first controller read data for both banks.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_read_data_A <= '0;
      bus.o_read_data_B <= '0;
    end else begin
      bus.o_read_data_A <= mem_a[bus.i_address_A];
      bus.o_read_data_B <= mem_b[bus.i_address_B];
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: host beat beats start beats readback in IDLE; other states run to completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (first_beat)     state_nxt = LOAD;
        else if (start_acc) state_nxt = RUN;
        else if (rd_acc)    state_nxt = READ;
      end
      LOAD: if (last_beat) state_nxt = IDLE;
      RUN:  if (run_done)  state_nxt = IDLE;
      READ: if (rd_cnt == RD_W'(BEATS + 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; ready is forced low while reset is held.
  always_comb begin
    bus.o_host_ready = !i_rst && ((state == IDLE) || (state == LOAD));
    bus.o_busy       = (state == RUN) || (state == READ);
    bus.o_rd_valid   = (state == READ) && (rd_cnt >= RD_W'(2));
    rd_beat          = CNT_W'(rd_cnt - RD_W'(2));
    bus.o_rd_data    = '0;
    if (bus.o_rd_valid) bus.o_rd_data = rd_line[rd_beat*HOST_W +: HOST_W];
  end

  // Line assembly, readback capture/sequencing, sticky done flag and collision error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt            <= '0;
      asm_line       <= '0;
      hbank          <= 1'b0;
      haddr          <= '0;
      rbank          <= 1'b0;
      raddr          <= '0;
      rd_line        <= '0;
      rd_cnt         <= '0;
      bus.o_done     <= 1'b0;
      bus.o_host_err <= 1'b0;
    end else begin
      bus.o_host_err <= last_beat && collide;

      if (first_beat) begin
        hbank                  <= bus.i_host_bank;
        haddr                  <= bus.i_host_addr;
        asm_line[HOST_W-1:0]   <= bus.i_host_data;
        cnt                    <= CNT_W'(1);
      end else if (beat_acc && (state == LOAD)) begin
        asm_line[cnt*HOST_W +: HOST_W] <= bus.i_host_data;
        cnt                            <= cnt + CNT_W'(1);  // wraps to 0 on the last beat
      end

      if (start_acc)     bus.o_done <= 1'b0;
      else if (run_done) bus.o_done <= 1'b1;

      if (rd_acc) begin
        rbank  <= bus.i_rd_bank;
        raddr  <= bus.i_rd_addr;
        rd_cnt <= '0;
      end else if (state == READ) begin
        // snapshot once so controller writes during the burst cannot tear the line
        if (rd_cnt == '0) rd_line <= rbank ? mem_b[raddr] : mem_a[raddr];
        rd_cnt <= rd_cnt + RD_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_spmv_sram_responder.sv
// Bench for spmv_sram_responder: vector table, directed corner sequences and randomized traffic.
// Reference is a plain array model of both banks updated per clock edge from the driven inputs.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_spmv_sram_responder;
  logic clk;
  logic rst;

  spmv_sram_responder_if bus ();

  spmv_sram_responder dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rdv_seen = 0;

  logic [255:0] ma [32];
  logic [255:0] mb [32];
  bit           mem_known = 0;
  bit           commit_now = 0;
  bit           start_now = 0;
  bit           cbank;
  logic [4:0]   caddr;
  logic [255:0] cline;

  always @(negedge clk) if (bus.o_rd_valid === 1'b1) rdv_seen++;

  typedef struct {
    bit          we;
    logic [4:0]  addr;
    logic [31:0] wdat;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock edge: predict read data and memory effects from the current inputs, then compare.
  task automatic step();
    logic [255:0] ea, eb;
    bit col;
    ea  = ma[bus.i_address_A];
    eb  = mb[bus.i_address_B];
    col = 1'b0;
    if (commit_now) begin
      col = cbank ? (bus.i_wr_en_B && bus.i_address_B == caddr)
                  : (bus.i_wr_en_A && bus.i_address_A == caddr);
      if (!col) begin
        if (cbank) mb[caddr] = cline;
        else       ma[caddr] = cline;
      end
    end
    if (start_now) ma[0] = 256'h1;
    if (bus.i_wr_en_A) ma[bus.i_address_A] = bus.i_write_data_A;
    if (bus.i_wr_en_B) mb[bus.i_address_B] = bus.i_write_data_B;
    @(posedge clk);
    #1;
    if (mem_known) begin
      chk("read_data_A", bus.o_read_data_A, ea);
      chk("read_data_B", bus.o_read_data_B, eb);
    end
    chk("host_err", 256'(bus.o_host_err), 256'(col));
  endtask

  task automatic ctrl_idle();
    bus.i_wr_en_A = 1'b0;
    bus.i_wr_en_B = 1'b0;
  endtask

  task automatic rnd_ctrl_ops(input int n);
    bus.i_wr_en_A      = 1'($urandom);
    bus.i_wr_en_B      = 1'($urandom);
    bus.i_address_A    = 5'($urandom_range(n - 1, 0));
    bus.i_address_B    = 5'($urandom_range(n - 1, 0));
    bus.i_write_data_A = rnd256();
    bus.i_write_data_B = rnd256();
  endtask

  // Send a full line as 8 beats; bank/addr are only meaningful on beat 0, so later beats carry junk.
  task automatic host_line(input bit bank, input logic [4:0] addr, input logic [255:0] line,
                           input int gap_max, input bit rnd_ctrl, input bit coll);
    for (int k = 0; k < 8; k++) begin
      bus.i_host_valid = 1'b1;
      bus.i_host_bank  = (k == 0) ? bank : 1'($urandom);
      bus.i_host_addr  = (k == 0) ? addr : 5'($urandom);
      bus.i_host_data  = line[k*32 +: 32];
      if (rnd_ctrl) rnd_ctrl_ops(4);
      if (k == 7) begin
        commit_now = 1'b1; cbank = bank; caddr = addr; cline = line;
        if (coll) begin
          if (bank) begin bus.i_wr_en_B = 1'b1; bus.i_address_B = addr; bus.i_write_data_B = 256'h7; end
          else      begin bus.i_wr_en_A = 1'b1; bus.i_address_A = addr; bus.i_write_data_A = 256'h7; end
        end
      end
      chk("host_ready", 256'(bus.o_host_ready), 256'h1);
      step();
      commit_now = 1'b0;
      bus.i_start = 1'b0;
      bus.i_rd_req = 1'b0;
      bus.i_host_valid = 1'b0;
      ctrl_idle();
      if (k < 7) begin
        int g;
        g = $urandom_range(gap_max, 0);
        for (int j = 0; j < g; j++) begin
          if (rnd_ctrl) rnd_ctrl_ops(4);
          step();
          ctrl_idle();
        end
      end
    end
  endtask

  task automatic readback(input bit bank, input logic [4:0] addr, input bit rnd_ctrl);
    logic [255:0] exp_line;
    int nv, first;
    bus.i_rd_req = 1'b1; bus.i_rd_bank = bank; bus.i_rd_addr = addr;
    step();
    bus.i_rd_req = 1'b0; bus.i_rd_bank = ~bank; bus.i_rd_addr = ~addr;
    nv = 0; first = -1; exp_line = '0;
    for (int i = 1; i <= 12; i++) begin
      if (rnd_ctrl) begin
        if (bank) begin bus.i_wr_en_B = 1'b1; bus.i_address_B = addr; bus.i_write_data_B = rnd256(); end
        else      begin bus.i_wr_en_A = 1'b1; bus.i_address_A = addr; bus.i_write_data_A = rnd256(); end
      end
      if (i == 1) exp_line = bank ? mb[addr] : ma[addr];
      step();
      ctrl_idle();
      if (bus.o_rd_valid) begin
        if (first < 0) first = i;
        chk("rd_contig", 256'(i - first), 256'(nv));
        if (nv < 8) chk($sformatf("rd_beat%0d", nv), 256'(bus.o_rd_data), 256'(exp_line[nv*32 +: 32]));
        nv++;
      end
    end
    chk("rd_first", 256'(first), 256'd2);
    chk("rd_count", 256'(nv), 256'd8);
    chk("rd_busy_end", 256'(bus.o_busy), 256'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 256'(bus.o_host_ready), 256'h0);
    chk({tag, "_busy"},  256'(bus.o_busy), 256'h0);
    chk({tag, "_done"},  256'(bus.o_done), 256'h0);
    chk({tag, "_rdv"},   256'(bus.o_rd_valid), 256'h0);
    chk({tag, "_rdd"},   256'(bus.o_rd_data), 256'h0);
    chk({tag, "_err"},   256'(bus.o_host_err), 256'h0);
    chk({tag, "_rdA"},   bus.o_read_data_A, 256'h0);
    chk({tag, "_rdB"},   bus.o_read_data_B, 256'h0);
  endtask

  initial begin
    vec_t vecs [10];
    logic [255:0] l, old2;
    int rdv0;

    vecs[0] = '{1'b1, 5'd4,  32'h11,       1'b0, 32'h0};
    vecs[1] = '{1'b1, 5'd5,  32'h22,       1'b0, 32'h0};
    vecs[2] = '{1'b0, 5'd4,  32'h0,        1'b1, 32'h11};
    vecs[3] = '{1'b1, 5'd4,  32'h33,       1'b1, 32'h11};
    vecs[4] = '{1'b0, 5'd4,  32'h0,        1'b1, 32'h33};
    vecs[5] = '{1'b0, 5'd5,  32'h0,        1'b1, 32'h22};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 5'd31, 32'h0,        1'b1, 32'hFFFFFFFF};
    vecs[8] = '{1'b1, 5'd0,  32'h5,        1'b0, 32'h0};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b1, 32'h5};

    rst = 1'b1;
    bus.i_address_A = '0; bus.i_address_B = '0; ctrl_idle();
    bus.i_write_data_A = '0; bus.i_write_data_B = '0;
    bus.i_host_valid = 1'b0; bus.i_host_bank = 1'b0; bus.i_host_addr = '0; bus.i_host_data = '0;
    bus.i_start = 1'b0; bus.i_rd_req = 1'b0; bus.i_rd_bank = 1'b0; bus.i_rd_addr = '0;
    for (int i = 0; i < 32; i++) begin ma[i] = '0; mb[i] = '0; end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // controller port vector table on bank A
    for (int i = 0; i < 10; i++) begin
      bus.i_wr_en_A = vecs[i].we; bus.i_address_A = vecs[i].addr;
      bus.i_write_data_A = 256'(vecs[i].wdat);
      step();
      if (vecs[i].chk) chk($sformatf("vec%0d", i), bus.o_read_data_A, 256'(vecs[i].exp));
    end
    ctrl_idle();

    // fill both banks with known random contents
    for (int a = 0; a < 32; a++) begin
      bus.i_wr_en_A = 1'b1; bus.i_wr_en_B = 1'b1;
      bus.i_address_A = 5'(a); bus.i_address_B = 5'(a);
      bus.i_write_data_A = rnd256(); bus.i_write_data_B = rnd256();
      step();
    end
    ctrl_idle();
    mem_known = 1;

    // host load of B[0] then controller read
    l = '0; l[63:32] = 32'h100;
    host_line(1'b1, 5'd0, l, 2, 1'b0, 1'b0);
    bus.i_address_B = 5'd0;
    step();
    chk("B0_line", bus.o_read_data_B, l);

    // host beat beats start and readback request; then a real start
    rdv0 = rdv_seen;
    bus.i_start = 1'b1; bus.i_rd_req = 1'b1;
    host_line(1'b0, 5'd0, 256'h0, 1, 1'b0, 1'b0);
    chk("prio_beat_busy", 256'(bus.o_busy), 256'h0);
    bus.i_start = 1'b1; start_now = 1'b1;
    step();
    bus.i_start = 1'b0; start_now = 1'b0;
    chk("run_busy", 256'(bus.o_busy), 256'h1);
    chk("run_ready", 256'(bus.o_host_ready), 256'h0);
    chk("run_done0", 256'(bus.o_done), 256'h0);
    bus.i_address_A = 5'd0;
    step();
    chk("run_flag", bus.o_read_data_A, 256'h1);
    // beat and readback request in RUN are ignored
    bus.i_host_valid = 1'b1; bus.i_host_data = 32'hBAD; bus.i_rd_req = 1'b1;
    step();
    bus.i_host_valid = 1'b0; bus.i_rd_req = 1'b0;
    bus.i_wr_en_A = 1'b1; bus.i_address_A = 5'd5; bus.i_write_data_A = 256'hDEAD;
    step();
    chk("run_still_busy", 256'(bus.o_busy), 256'h1);
    bus.i_address_A = 5'd0; bus.i_write_data_A = 256'h2;
    step();
    ctrl_idle();
    chk("run_done", 256'(bus.o_done), 256'h1);
    chk("run_idle", 256'(bus.o_busy), 256'h0);
    repeat (3) step();
    chk("no_rdv_prio_run", 256'(rdv_seen - rdv0), 256'h0);
    readback(1'b0, 5'd5, 1'b0);

    // commit collision on A[3]
    host_line(1'b0, 5'd3, rnd256(), 1, 1'b0, 1'b1);
    bus.i_address_A = 5'd3;
    step();
    chk("coll_A3", bus.o_read_data_A, 256'h7);

    // start beats same-cycle readback request; start clears sticky done
    rdv0 = rdv_seen;
    bus.i_start = 1'b1; bus.i_rd_req = 1'b1; bus.i_rd_bank = 1'b0; bus.i_rd_addr = 5'd5;
    start_now = 1'b1;
    step();
    bus.i_start = 1'b0; bus.i_rd_req = 1'b0; start_now = 1'b0;
    chk("s2_busy", 256'(bus.o_busy), 256'h1);
    chk("s2_done_clr", 256'(bus.o_done), 256'h0);
    bus.i_rd_req = 1'b1;
    step();
    bus.i_rd_req = 1'b0;
    step();
    bus.i_wr_en_A = 1'b1; bus.i_address_A = 5'd0; bus.i_write_data_A = 256'h2;
    step();
    ctrl_idle();
    chk("s2_done", 256'(bus.o_done), 256'h1);
    repeat (12) step();
    chk("s2_no_rdv", 256'(rdv_seen - rdv0), 256'h0);

    // reset in the middle of a load
    old2 = ma[2];
    for (int k = 0; k < 4; k++) begin
      bus.i_host_valid = 1'b1; bus.i_host_bank = 1'b0; bus.i_host_addr = 5'd2;
      bus.i_host_data = 32'hA0 + 32'(k);
      step();
    end
    bus.i_host_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_load");
    @(negedge clk);
    rst = 1'b0;
    bus.i_address_A = 5'd2;
    step();
    chk("rst_load_A2_old", bus.o_read_data_A, old2);
    l = rnd256();
    host_line(1'b0, 5'd2, l, 1, 1'b0, 1'b0);
    step();
    chk("rst_load_A2_new", bus.o_read_data_A, l);

    // reset in the middle of a readback burst
    bus.i_rd_req = 1'b1; bus.i_rd_bank = 1'b1; bus.i_rd_addr = 5'd7;
    step();
    bus.i_rd_req = 1'b0;
    repeat (3) step();
    chk("rst_read_rdv_before", 256'(bus.o_rd_valid), 256'h1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_read");
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(2, 0))
        0: begin rnd_ctrl_ops(32); step(); ctrl_idle(); end
        1: host_line(1'($urandom), 5'($urandom_range(3, 0)), rnd256(), 2, 1'b1, 1'b0);
        default: readback(1'($urandom), 5'($urandom), 1'($urandom));
      endcase
    end

    // final sweep of both banks
    for (int a = 0; a < 32; a++) begin
      bus.i_address_A = 5'(a); bus.i_address_B = 5'(31 - a);
      step();
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spmv_sram_responder.md
Name: spmv_sram_responder

Overview:
- Memory-side responder for the SpMV ops controller's SRAM interface. It holds two 32x256 banks: A holds values/results and B holds column indices.
- It answers the controller's address/wr_en/write-data requests with registered read data.
- It exposes a 32-bit host port for three things: loading banks beat-by-beat, starting a run through the A[0] flag word, and streaming lines back out.
- It is the counterpart the controller polls and writes to. It replaces testbench-driven read data in integrated builds.

Parameters:
- DATA_W, 256, line width of each bank
- ADDR_W, 5, line address width (DEPTH = 2**ADDR_W = 32)
- HOST_W, 32, host beat width; BEATS = DATA_W/HOST_W = 8

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_address_A  in  ADDR_W  controller line address, bank A
- i_address_B  in  ADDR_W  controller line address, bank B
- i_wr_en_A  in  1  controller write enable, bank A
- i_wr_en_B  in  1  controller write enable, bank B
- i_write_data_A  in  DATA_W  controller write data, bank A
- i_write_data_B  in  DATA_W  controller write data, bank B
- o_read_data_A  out  DATA_W  registered read data, bank A
- o_read_data_B  out  DATA_W  registered read data, bank B
- i_host_valid  in  1  host load beat valid
- o_host_ready  out  1  host load beat accepted when high with valid
- i_host_bank  in  1  0=A, 1=B; sampled on first beat of a line
- i_host_addr  in  ADDR_W  line address; sampled on first beat
- i_host_data  in  HOST_W  load beat; first beat = bits [31:0]
- o_host_err  out  1  one-cycle pulse: host line commit lost to controller write
- i_start  in  1  run request pulse
- i_rd_req  in  1  readback request pulse
- i_rd_bank  in  1  readback bank
- i_rd_addr  in  ADDR_W  readback line
- o_rd_valid  out  1  readback beat valid
- o_rd_data  out  HOST_W  readback beat, low word first
- o_busy  out  1  high in RUN or READ
- o_done  out  1  run completed; sticky

Behaviour:
- Reset (async):
  - FSM goes to IDLE; beat counter = 0.
  - All outputs are 0, including both read-data registers.
  - The memory arrays are not reset and keep their contents across reset.
- Controller port, active in every state:
  - o_read_data_X = mem_X[i_address_X] one cycle after the address is presented (read-first).
  - If i_wr_en_X is high, the write happens at the clock edge. A same-address read in that cycle returns the old data.
- FSM states: IDLE, LOAD, RUN, READ.
- IDLE:
  - o_host_ready = 1.
  - An accepted beat latches bank/addr, stores the beat in slot 0 of the assembly register, sets count = 1, and moves to LOAD.
  - If i_start is high and no beat is accepted, A[0] is written with 256'h1 at that edge, o_done is cleared, and the FSM moves to RUN.
  - Otherwise, if i_rd_req is high, the request is latched and the FSM moves to READ.
  - Priority in IDLE: host beat > i_start > i_rd_req. The losers are dropped.
- LOAD:
  - o_host_ready = 1. Each accepted beat fills slot count, and count increments.
  - On the 8th beat, the line commits to mem[bank][addr] at that edge and the FSM returns to IDLE.
  - i_start and i_rd_req are ignored in LOAD.
  - Valid gaps between beats are allowed.
- Commit collision: if the controller writes the same bank and address on the commit edge, the controller data wins. The host line is discarded and o_host_err pulses for one cycle.
- RUN:
  - o_host_ready = 0; i_start and i_rd_req are ignored.
  - A controller write to A address 0 with i_write_data_A[1] = 1 sets o_done = 1 at the next edge and returns the FSM to IDLE. The write itself is still stored.
- o_done stays high until the next accepted i_start or reset.
- READ:
  - The edge after the request reads the latched line.
  - o_rd_valid is high for 8 consecutive cycles, starting 2 cycles after the i_rd_req edge. Beat k = bits [32k+31:32k].
  - There is no backpressure. The FSM returns to IDLE after beat 7.
  - Line data is captured once at read time; controller writes during the burst do not alter it.
- o_busy = (state == RUN) or (state == READ).
- Reset mid-LOAD: the partial line is discarded with no write. Reset mid-READ: o_rd_valid drops immediately.

Test Plan:
- Reset, then load bank B line 0 with beats 0x00000000, 0x00000100, then 6 beats of 0 → controller reads B addr 0 and gets 0x..._00000100_00000000 one cycle later; o_host_ready stays 1 throughout.
- Load A[0] = 0, pulse i_start → next cycle o_busy=1; controller read of A addr 0 returns 256'h1; o_host_ready=0 while in RUN.
- In RUN, controller writes A[5]=256'hDEAD, then writes A[0]=256'h2 → o_done=1 the next cycle, o_busy=0; readback of A[5] gives beat0=0xDEAD, beats1-7=0, with o_rd_valid high for exactly 8 cycles.
- Host's 8th beat to A[3] coincides with a controller write of A[3]=256'h7 → o_host_err pulses once; A[3] reads 256'h7.
- Assert i_rst after 4 of 8 beats to A[2], then read A[2] → old contents are unchanged; FSM is in IDLE and the next beat starts a new line at slot 0.
- Same-cycle i_start and i_rd_req in IDLE → start wins, no o_rd_valid; i_rd_req during RUN → ignored.
